// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Registered MAC back end. Sums the unsigned 16-bit products coming out of
//   the 8x8 multiplier into an ACC_W-bit accumulator. A result is produced
//   after LEN products, or earlier when flush ends a non-empty run. Each result
//   is held on a valid/ready port until downstream takes it.
//
// Optional feature macro: PROD_ACC_SAT_EN
//   defined   : the accumulator saturates at all ones and ovf reports it
//   undefined : the accumulator wraps modulo 2^ACC_W and ovf is tied to 0
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   prod_valid  upstream product valid
//   prod_ready  stage can accept a product this cycle (high only in ACC)
//   prod        16-bit unsigned product
//   flush       end the current run early (single-cycle pulse)
//   res_valid   result valid
//   res_ready   downstream accepts result
//   res         accumulated sum
//   res_cnt     number of products summed into res
//   ovf         saturation happened in this result
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. Once res_valid is raised, res/res_cnt/ovf stay
// stable and res_valid stays high until that transfer. prod_ready depends on
// the FSM state only, never on res_ready.
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN   = 8,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [15:0]      prod,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res,
  output logic [CNT_W-1:0] res_cnt,
  output logic             ovf
);

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             beat;
  logic             done;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] acc_after;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_after;

  assign prod_ready = (state == S_ACC);
  assign beat       = prod_valid & prod_ready;

`ifdef PROD_ACC_SAT_EN
  // One extra bit catches the carry out; once acc is all ones any further
  // non-zero add carries again, so the clamp is self-sustaining.
  logic [ACC_W:0] sum_full;
  logic           sticky;
  logic           sticky_after;

  assign sum_full     = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign acc_add      = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
  assign sticky_after = sticky | (beat & sum_full[ACC_W]);
`else
  assign acc_add = acc + ACC_W'(prod);
`endif

  // Values of the run after this cycle's beat (if any); a finishing run
  // publishes these so the last beat is included in the result.
  assign acc_after = beat ? acc_add : acc;
  assign cnt_after = beat ? cnt + CNT_W'(1) : cnt;

  // End of run: count reaches LEN, or flush with something to report.
  // A flush on an empty run with no beat is dropped.
  assign done = (beat && (cnt_after == CNT_W'(LEN))) ||
                (flush && ((cnt != '0) || beat));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_ACC) begin
      if (done) begin
        state_nxt = S_OUT;
      end
    end else begin
      if (res_ready) begin
        state_nxt = S_ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      res       <= '0;
      res_cnt   <= '0;
      res_valid <= 1'b0;
    end else if (state == S_ACC) begin
      acc <= acc_after;
      cnt <= cnt_after;
      if (done) begin
        res       <= acc_after;
        res_cnt   <= cnt_after;
        res_valid <= 1'b1;
      end
    end else if (res_ready) begin
      // Result taken: start a fresh run; prod_ready returns next cycle.
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
    end
  end

`ifdef PROD_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == S_ACC) begin
      sticky <= sticky_after;
      if (done) begin
        ovf <= sticky_after;
      end
    end else if (res_ready) begin
      sticky <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int ACC_W   = 24;
  localparam int LEN     = 8;
  localparam int CNT_W   = $clog2(LEN + 1);
  localparam int ACC_W_S = 17;
  localparam int LEN_S   = 3;
  localparam int CNT_W_S = $clog2(LEN_S + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // ---------------- main DUT (ACC_W=24, LEN=8) ----------------
  logic             prod_valid = 1'b0;
  logic             prod_ready;
  logic [15:0]      prod = '0;
  logic             flush = 1'b0;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res;
  logic [CNT_W-1:0] res_cnt;
  logic             ovf;

  logic rand_rr  = 1'b0;
  logic rr_fixed = 1'b0;
  logic rr_bit   = 1'b0;
  assign res_ready = rand_rr ? rr_bit : rr_fixed;
  always @(negedge clk) rr_bit = ($urandom_range(0, 2) != 0);

  product_accumulator #(.ACC_W(ACC_W), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .res_cnt(res_cnt), .ovf(ovf)
  );

  // ---------------- small DUT (ACC_W=17, LEN=3) ----------------
  logic               prod_valid_s = 1'b0;
  logic               prod_ready_s;
  logic [15:0]        prod_s = '0;
  logic               flush_s = 1'b0;
  logic               res_valid_s;
  logic               res_ready_s = 1'b1;
  logic [ACC_W_S-1:0] res_s;
  logic [CNT_W_S-1:0] res_cnt_s;
  logic               ovf_s;

  product_accumulator #(.ACC_W(ACC_W_S), .LEN(LEN_S)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(prod_valid_s), .prod_ready(prod_ready_s), .prod(prod_s), .flush(flush_s),
    .res_valid(res_valid_s), .res_ready(res_ready_s), .res(res_s), .res_cnt(res_cnt_s), .ovf(ovf_s)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [ACC_W-1:0]   exp_q[$];
  logic [CNT_W-1:0]   exp_cnt_q[$];
  logic               exp_ovf_q[$];
  logic [ACC_W_S-1:0] exp_s_q[$];
  logic [CNT_W_S-1:0] exp_cnt_s_q[$];
  logic               exp_ovf_s_q[$];

  int unsigned run_q[$];
  int unsigned run_s_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: true sum of the run, then clamp or wrap into w bits.
  function automatic void fold(input longint sum, input int w,
                               output logic [63:0] r, output logic o);
    longint lim;
    lim = longint'(1) << w;
`ifdef PROD_ACC_SAT_EN
    if (sum >= lim) begin
      r = 64'(lim - 1);
      o = 1'b1;
    end else begin
      r = 64'(sum);
      o = 1'b0;
    end
`else
    r = 64'(sum % lim);
    o = 1'b0;
`endif
  endfunction

  function automatic void close_run();
    longint      s;
    logic [63:0] r;
    logic        o;
    s = 0;
    foreach (run_q[i]) s += longint'(run_q[i]);
    fold(s, ACC_W, r, o);
    exp_q.push_back(r[ACC_W-1:0]);
    exp_cnt_q.push_back(CNT_W'(run_q.size()));
    exp_ovf_q.push_back(o);
    run_q.delete();
  endfunction

  function automatic void close_run_s();
    longint      s;
    logic [63:0] r;
    logic        o;
    s = 0;
    foreach (run_s_q[i]) s += longint'(run_s_q[i]);
    fold(s, ACC_W_S, r, o);
    exp_s_q.push_back(r[ACC_W_S-1:0]);
    exp_cnt_s_q.push_back(CNT_W_S'(run_s_q.size()));
    exp_ovf_s_q.push_back(o);
    run_s_q.delete();
  endfunction

  // ---------------- monitors (sample at negedge + 2) ----------------
  logic             held = 1'b0;
  logic [ACC_W-1:0] held_res;
  logic [CNT_W-1:0] held_cnt;
  logic             held_ovf;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      held = 1'b0;
    end else if (res_valid) begin
      if (held) begin
        chk("hold_res", 64'(res), 64'(held_res));
        chk("hold_cnt", 64'(res_cnt), 64'(held_cnt));
        chk("hold_ovf", 64'(ovf), 64'(held_ovf));
      end
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(1), 64'(0));
        end else begin
          chk("res", 64'(res), 64'(exp_q.pop_front()));
          chk("res_cnt", 64'(res_cnt), 64'(exp_cnt_q.pop_front()));
          chk("ovf", 64'(ovf), 64'(exp_ovf_q.pop_front()));
        end
        held = 1'b0;
      end else begin
        held     = 1'b1;
        held_res = res;
        held_cnt = res_cnt;
        held_ovf = ovf;
      end
    end else begin
      if (held) chk("valid_drop", 64'(res_valid), 64'(1));
      held = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst_n && res_valid_s && res_ready_s) begin
      if (exp_s_q.size() == 0) begin
        chk("unexpected_result_s", 64'(1), 64'(0));
      end else begin
        chk("res_s", 64'(res_s), 64'(exp_s_q.pop_front()));
        chk("res_cnt_s", 64'(res_cnt_s), 64'(exp_cnt_s_q.pop_front()));
        chk("ovf_s", 64'(ovf_s), 64'(exp_ovf_s_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (entered and left just after a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input logic [15:0] p, input logic fl);
    int n;
    n = 0;
    prod_valid = 1'b1;
    prod       = p;
    flush      = fl;
    while (!prod_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!prod_ready) begin
      chk("beat_timeout", 64'(prod_ready), 64'(1));
    end else begin
      @(posedge clk);
      run_q.push_back(int'(p));
      if (run_q.size() == LEN || fl) close_run();
      @(negedge clk);
    end
    prod_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic flush_only();
    int n;
    n = 0;
    while (!prod_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!prod_ready) begin
      chk("flush_timeout", 64'(prod_ready), 64'(1));
    end else begin
      flush = 1'b1;
      @(posedge clk);
      if (run_q.size() != 0) close_run();
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  task automatic beat_s(input logic [15:0] p);
    int n;
    n = 0;
    prod_valid_s = 1'b1;
    prod_s       = p;
    while (!prod_ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!prod_ready_s) begin
      chk("beat_s_timeout", 64'(prod_ready_s), 64'(1));
    end else begin
      @(posedge clk);
      run_s_q.push_back(int'(p));
      if (run_s_q.size() == LEN_S) close_run_s();
      @(negedge clk);
    end
    prod_valid_s = 1'b0;
  endtask

  task automatic accept();
    rr_fixed = 1'b1;
    @(negedge clk);
    rr_fixed = 1'b0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    prod_valid   = 1'b0;
    flush        = 1'b0;
    prod_valid_s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_q.delete();
    run_s_q.delete();
    exp_q.delete();
    exp_cnt_q.delete();
    exp_ovf_q.delete();
    exp_s_q.delete();
    exp_cnt_s_q.delete();
    exp_ovf_s_q.delete();
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_prod_ready", 64'(prod_ready), 64'(1));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_res_cnt", 64'(res_cnt), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    @(negedge clk);
    do_reset();

    // Full run of maximum products, result held under backpressure.
    for (int i = 0; i < LEN; i++) beat(16'd65025, 1'b0);
    chk("t1_res_valid", 64'(res_valid), 64'(1));
    chk("t1_prod_ready", 64'(prod_ready), 64'(0));
    chk("t1_res", 64'(res), 64'h07F008);
    chk("t1_res_cnt", 64'(res_cnt), 64'(8));

    prod_valid = 1'b1;
    prod       = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_stall_res", 64'(res), 64'h07F008);
      chk("t2_stall_ready", 64'(prod_ready), 64'(0));
    end
    rr_fixed = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    rr_fixed   = 1'b0;
    chk("t2_ready_back", 64'(prod_ready), 64'(1));
    chk("t2_valid_gone", 64'(res_valid), 64'(0));

    // Early end with flush on the third beat.
    beat(16'd100, 1'b0);
    beat(16'd200, 1'b0);
    beat(16'd300, 1'b1);
    chk("t3_res_valid", 64'(res_valid), 64'(1));
    chk("t3_res", 64'(res), 64'(600));
    chk("t3_res_cnt", 64'(res_cnt), 64'(3));
    accept();

    // Flush on an empty run must not produce a result.
    flush_only();
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_result", 64'(res_valid), 64'(0));
      @(negedge clk);
    end
    for (int i = 0; i < LEN; i++) beat(16'($urandom_range(0, 65535)), 1'b0);
    chk("t4_res_cnt", 64'(res_cnt), 64'(8));
    accept();

    // Reset in the middle of a run discards it.
    for (int i = 0; i < 5; i++) beat(16'd1000, 1'b0);
    do_reset();
    for (int i = 0; i < LEN; i++) beat(16'd1, 1'b0);
    chk("t5_res", 64'(res), 64'(8));
    chk("t5_res_cnt", 64'(res_cnt), 64'(8));
    accept();

    // Randomized traffic with random downstream readiness.
    rand_rr = 1'b1;
    for (int i = 0; i < 250; i++) begin
      n = int'($urandom_range(0, 9));
      if (n < 2) idle(1);
      else if (n == 2) flush_only();
      else beat(16'($urandom_range(0, 65535)), ($urandom_range(0, 5) == 0));
    end
    flush_only();
    rand_rr  = 1'b0;
    rr_fixed = 1'b1;

    // Narrow accumulator: overflow on the first run, none on the second.
    for (int i = 0; i < LEN_S; i++) beat_s(16'd65025);
    beat_s(16'd1);
    beat_s(16'd2);
    beat_s(16'd3);

    n = 0;
    while ((exp_q.size() != 0 || exp_s_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_main", 64'(exp_q.size()), 64'(0));
    chk("drain_small", 64'(exp_s_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
